// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_pkg;

    // Sequencer states; encodings 12..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_SHL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // All control strobes and selects driven into the datapath.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] aluop;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Control-output decoder: maps the current state (plus run/mem_ready) to strobes.
// Latency: purely combinational.
// Backpressure: mem_ready only qualifies ir_write/pc_write in FETCH and instr_done in MEMWR.
module mc_outdec
    import mc_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    input  logic        run,
    output ctrl_t       ctrl
);

    // Moore decode of state; everything is held at zero until run is set.
    always_comb begin
        ctrl = '0;
        if (run) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.aluop     = ALU_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b  = SRCB_SHL2;
                    ctrl.aluop      = ALU_ADD;
                    ctrl.illegal_op = !op_supported(opcode);
                end
                S_MEMADR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.mem_write  = 1'b1;
                    ctrl.iord       = 1'b1;
                    ctrl.instr_done = mem_ready;
                end
                S_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.aluop     = ALU_FUNCT;
                end
                S_RWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_REG;
                    ctrl.aluop         = ALU_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                    ctrl.instr_done    = 1'b1;
                end
                S_JUMP: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_source  = PCSRC_JUMP;
                    ctrl.instr_done = 1'b1;
                end
                S_ADDI_EX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                end
                S_ADDI_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS sequencer: state register, next-state logic, run flag, retire counter.
// Latency: R 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2 cycles at full memory rate.
// Backpressure: mem_ready low holds FETCH/MEMRD/MEMWR one extra cycle per low cycle.
module mc_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  aluop,
    output logic [1:0]  pc_source,
    output logic        instr_done,
    output logic        illegal_op,
    output logic [31:0] retired,
    output logic [3:0]  state
);

    state_t      state_q, state_d;
    logic        run_q, run_d;
    logic [31:0] retired_q, retired_d;
    ctrl_t       ctrl;

    // The zero flag is combined with pc_write_cond in the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    mc_outdec u_outdec (
        .state     (state_q),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .run       (run_q),
        .ctrl      (ctrl)
    );

    // Next state: sequence each opcode, stall on mem_ready, recover unused codes.
    always_comb begin
        state_d = S_FETCH;
        if (run_q) begin
            case (state_q)
                S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_R:         state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        OP_ADDI:      state_d = S_ADDI_EX;
                        default:      state_d = S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (opcode == OP_LW)      state_d = S_MEMRD;
                    else if (opcode == OP_SW) state_d = S_MEMWR;
                    else                      state_d = S_FETCH;
                end
                S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
                S_EXEC:    state_d = S_RWB;
                S_ADDI_EX: state_d = S_ADDI_WB;
                default:   state_d = S_FETCH;
            endcase
        end
    end

    // run latches high one edge after reset release; retired counts done pulses.
    always_comb begin
        run_d     = 1'b1;
        retired_d = retired_q + {31'd0, ctrl.instr_done};
    end

    // State, run and retire registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            run_q     <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            retired_q <= retired_d;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign aluop         = ctrl.aluop;
    assign pc_source     = ctrl.pc_source;
    assign instr_done    = ctrl.instr_done;
    assign illegal_op    = ctrl.illegal_op;
    assign retired       = retired_q;
    assign state         = state_q;

endmodule
